// File: rtl/ifetch_stage.sv
// Instruction fetch: PC + in-order imem req/gnt/rvalid, buffered words handed to decode.
// Latency: rvalid at cycle N gives id_valid at N+1; redirect resumes fetch one cycle later.
// Backpressure: id_ready low holds the FIFO head; issue stops once FIFO/outstanding credits run out.

module ifetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop   = pop && (count != '0);
    // A full FIFO still accepts a push when it is popped in the same cycle.
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push)
            mem[wr_ptr] <= push_dat;
    end
endmodule

module ifetch_stage #(
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
    parameter int                    FIFO_DEPTH      = 2,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_instruction,
    output logic [DATA_WIDTH-1:0] id_pc
);
    localparam int FCW = $clog2(FIFO_DEPTH+1);
    localparam int OCW = $clog2(MAX_OUTSTANDING+1);
    localparam int SW  = ((FCW > OCW) ? FCW : OCW) + 1;

    logic [DATA_WIDTH-1:0]   pc;
    logic [OCW-1:0]          live;
    logic [OCW-1:0]          discard;
    logic [FCW-1:0]          fifo_count;
    logic [DATA_WIDTH-1:0]   tag_head;
    logic [2*DATA_WIDTH-1:0] fifo_head;
    logic                    accept;
    logic                    keep;
    logic                    drop;
    logic                    fifo_nonempty;
    logic                    unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    assign accept        = imem_req && imem_gnt;
    assign keep          = imem_rvalid && (discard == '0);
    assign drop          = imem_rvalid && (discard != '0);
    assign fifo_nonempty = !rst && (fifo_count != '0);

    // Credit rule: a kept response always has a FIFO slot waiting for it.
    assign imem_req = !rst && !redirect_valid
                   && ((SW'(live) + SW'(discard)) < SW'(MAX_OUTSTANDING))
                   && ((SW'(fifo_count) + SW'(live)) < SW'(FIFO_DEPTH));
    assign imem_addr = pc;

    assign id_valid       = fifo_nonempty && !redirect_valid;
    assign id_instruction = fifo_nonempty ? fifo_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign id_pc          = fifo_nonempty ? fifo_head[DATA_WIDTH-1:0] : '0;

    // Tag queue occupancy is exactly the number of live (kept) requests.
    ifetch_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (accept),
        .push_dat (pc),
        .pop      (keep && !redirect_valid),
        .head_dat (tag_head),
        .count    (live)
    );

    ifetch_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_instr_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (keep && !redirect_valid),
        .push_dat ({imem_rdata, tag_head}),
        .pop      (id_valid && id_ready),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            discard <= '0;
        end else if (redirect_valid) begin
            pc      <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            // Any response landing this cycle retires one outstanding request, kept or not.
            discard <= discard + live - OCW'(imem_rvalid);
        end else begin
            if (accept)
                pc <= pc + DATA_WIDTH'(4);
            if (drop)
                discard <= discard - OCW'(1);
        end
    end

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> ((live != '0) || (discard != '0)));
endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized bench for ifetch_stage: in-order imem model plus a stream-level reference of the decode sequence.
module tb_ifetch_stage;
    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          FD       = 2;
    localparam int          MO       = 2;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;

    ifetch_stage #(
        .DATA_WIDTH(DW), .RESET_PC(RESET_PC), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instruction(id_instruction), .id_pc(id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic        t_rst      = 1'b1;
    logic        t_redir    = 1'b0;
    logic        t_ready    = 1'b1;
    logic [31:0] t_redir_pc = 32'h0;
    int          gnt_pct    = 100;
    int          rv_pct     = 100;

    logic [31:0] pend[$];
    logic [31:0] exp_pc       = 32'h0;
    logic [31:0] fetch_pc     = 32'h0;
    bit          prev_stuck   = 0;
    logic [31:0] prev_addr    = 32'h0;
    bit          prev_hold    = 0;
    logic [31:0] prev_hold_pc = 32'h0;
    bit          popped       = 0;
    logic [31:0] pop_pc       = 32'h0;
    int          n_pops       = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: drive inputs, then judge the upcoming edge against the reference stream.
    task automatic step();
        int inflight;
        @(posedge clk);
        #1;
        rst            = t_rst;
        redirect_valid = t_redir;
        redirect_pc    = t_redir_pc;
        id_ready       = t_ready;
        imem_gnt       = ($urandom_range(99) < gnt_pct);
        if (t_rst) pend.delete();
        inflight    = pend.size();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!t_rst && pend.size() != 0 && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(pend.pop_front());
        end
        #1;
        popped = 0;
        if (t_rst) begin
            chk("rst_req", imem_req, 0);
            chk("rst_vld", id_valid, 0);
            chk("rst_instr", id_instruction, 0);
            chk("rst_pc", id_pc, 0);
            exp_pc     = RESET_PC;
            fetch_pc   = RESET_PC;
            prev_stuck = 0;
            prev_hold  = 0;
        end else if (t_redir) begin
            chk("redir_req", imem_req, 0);
            chk("redir_vld", id_valid, 0);
            exp_pc     = {t_redir_pc[31:2], 2'b00};
            fetch_pc   = {t_redir_pc[31:2], 2'b00};
            prev_stuck = 0;
            prev_hold  = 0;
        end else begin
            if (prev_stuck) begin
                chk("hold_req", imem_req, 1);
                chk("hold_addr", imem_addr, prev_addr);
            end
            if (prev_hold) begin
                chk("stall_vld", id_valid, 1);
                chk("stall_pc", id_pc, prev_hold_pc);
            end
            if (id_valid && id_ready) begin
                chk("id_pc", id_pc, exp_pc);
                chk("id_instr", id_instruction, word_at(exp_pc));
                popped = 1;
                pop_pc = id_pc;
                n_pops++;
                exp_pc = exp_pc + 32'd4;
            end
            if (imem_req && imem_gnt) begin
                chk("fetch_addr", imem_addr, fetch_pc);
                chk("outstanding_cap", 32'(inflight < MO), 1);
                pend.push_back(imem_addr);
                fetch_pc = fetch_pc + 32'd4;
            end
            prev_stuck   = imem_req && !imem_gnt;
            prev_addr    = imem_addr;
            prev_hold    = id_valid && !id_ready;
            prev_hold_pc = id_pc;
        end
    endtask

    task automatic wait_pop(input int lim);
        int k = 0;
        do begin
            step();
            k++;
        end while (!popped && k < lim);
        chk("pop_seen", 32'(popped), 1);
    endtask

    initial begin
        int p0;
        logic [31:0] a0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        // Straight-line fetch after reset
        t_rst = 1; step(); step();
        t_rst = 0; t_ready = 1; gnt_pct = 100; rv_pct = 100;
        step();
        chk("t1_req0", imem_req, 1);
        chk("t1_addr0", imem_addr, RESET_PC);
        chk("t1_vld0", id_valid, 0);
        chk("t1_instr0", id_instruction, 0);
        step();
        chk("t1_addr1", imem_addr, 32'h4);
        step();
        chk("t1_vld2", id_valid, 1);
        chk("t1_pc2", id_pc, 32'h0);
        p0 = n_pops;
        repeat (30) step();
        chk("t1_rate", 32'((n_pops - p0) >= 18), 1);

        // Decode stall: buffer fills, fetch stops, then drains in order
        t_ready = 0;
        repeat (10) step();
        chk("t2_req", imem_req, 0);
        chk("t2_vld", id_valid, 1);
        gnt_pct = 0; t_ready = 1; p0 = n_pops;
        repeat (5) step();
        chk("t2_buffered", n_pops - p0, FD);

        // Redirect with both requests in flight
        gnt_pct = 100; rv_pct = 0;
        for (int k = 0; k < 20 && pend.size() < MO; k++) step();
        chk("t3_inflight", pend.size(), MO);
        t_redir = 1; t_redir_pc = 32'h100; step();
        t_redir = 0; rv_pct = 100;
        wait_pop(20); chk("t3_pc0", pop_pc, 32'h100);
        wait_pop(20); chk("t3_pc1", pop_pc, 32'h104);

        // Redirect coinciding with an rvalid and a decode pop
        t_rst = 1; step();
        t_rst = 0; t_ready = 0; gnt_pct = 100; rv_pct = 100;
        step(); step();
        t_redir = 1; t_redir_pc = 32'h40; t_ready = 1; step();
        t_redir = 0; gnt_pct = 0; step();
        chk("t4_vld", id_valid, 0);
        chk("t4_addr", imem_addr, 32'h40);
        chk("t4_req", imem_req, 1);
        gnt_pct = 100;
        wait_pop(20); chk("t4_pc", pop_pc, 32'h40);

        // Alignment and PC wrap
        gnt_pct = 0; rv_pct = 100; repeat (4) step();
        t_redir = 1; t_redir_pc = 32'h203; step();
        t_redir = 0; step();
        chk("t5_align", imem_addr, 32'h200);
        t_redir = 1; t_redir_pc = 32'hFFFF_FFFC; step();
        t_redir = 0; gnt_pct = 100; step();
        chk("t5_top_req", imem_req, 1);
        chk("t5_top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("t5_wrap", imem_addr, 32'h0);
        wait_pop(20); chk("t5_pop_top", pop_pc, 32'hFFFF_FFFC);
        wait_pop(20); chk("t5_pop_wrap", pop_pc, 32'h0);

        // Grant withheld, then reset mid-burst
        gnt_pct = 0; repeat (3) step();
        a0 = imem_addr;
        repeat (5) begin
            step();
            chk("t6_stable", imem_addr, a0);
            chk("t6_req", imem_req, 1);
        end
        gnt_pct = 100; repeat (3) step();
        t_rst = 1; step();
        t_rst = 0; step();
        chk("t6_rst_addr", imem_addr, RESET_PC);
        chk("t6_rst_req", imem_req, 1);
        chk("t6_rst_vld", id_valid, 0);

        // Randomized traffic
        p0 = n_pops;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                gnt_pct = $urandom_range(100, 20);
                rv_pct  = $urandom_range(100, 20);
            end
            t_ready    = ($urandom_range(99) < 70);
            t_redir    = ($urandom_range(99) < 4);
            t_redir_pc = $urandom;
            t_rst      = ($urandom_range(999) < 5);
            step();
        end
        t_rst = 0; t_redir = 0;
        chk("rand_progress", 32'((n_pops - p0) > 300), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
